// File: rtl/sr_pkg.sv
// Shared FSM encoding and default timing for the SR latch pulse front end.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_PULSE_CYCLES    = 2;
  localparam int DEF_GAP_CYCLES      = 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchroniser followed by a persistence-count debouncer.
module sr_debounce
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  // Any cycle where sync agrees with the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 != dout) begin
        if (cnt == LAST) begin
          dout <= sync2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sr_pulse_gen.sv
// Debounced pushbuttons to clean, mutually exclusive S/R latch pulses.
module sr_pulse_gen
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_reset,
  output logic s,
  output logic r,
  output logic conflict,
  output logic busy
);

  localparam int CW = $clog2(max2(PULSE_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  logic stable_s, stable_r, stable_d_s, stable_d_r;
  logic req_s, req_r, want_s, want_r;
  logic pend_s, pend_r, pend_s_n, pend_r_n;
  logic conflict_n;
  logic [CW-1:0] cnt, cnt_n;
  state_t state, state_n;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_s (
    .clk(clk), .rst(rst), .din(btn_set), .dout(stable_s)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
    .clk(clk), .rst(rst), .din(btn_reset), .dout(stable_r)
  );

  assign req_s  = stable_s & ~stable_d_s;
  assign req_r  = stable_r & ~stable_d_r;
  assign want_s = req_s | pend_s;
  assign want_r = req_r | pend_r;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pend_s_n   = pend_s | req_s;
    pend_r_n   = pend_r | req_r;
    conflict_n = 1'b0;
    case (state)
      IDLE: begin
        // Simultaneous requests are ambiguous; drop both rather than guess.
        if (want_s && want_r) begin
          conflict_n = 1'b1;
          pend_s_n   = 1'b0;
          pend_r_n   = 1'b0;
        end else if (want_s) begin
          state_n  = PULSE_S;
          pend_s_n = 1'b0;
          cnt_n    = '0;
        end else if (want_r) begin
          state_n  = PULSE_R;
          pend_r_n = 1'b0;
          cnt_n    = '0;
        end
      end
      PULSE_S, PULSE_R: begin
        if (cnt == PULSE_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_s     <= 1'b0;
      pend_r     <= 1'b0;
      stable_d_s <= 1'b0;
      stable_d_r <= 1'b0;
      s          <= 1'b0;
      r          <= 1'b0;
      conflict   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pend_s     <= pend_s_n;
      pend_r     <= pend_r_n;
      stable_d_s <= stable_s;
      stable_d_r <= stable_r;
      s          <= (state_n == PULSE_S);
      r          <= (state_n == PULSE_R);
      conflict   <= conflict_n;
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Directed bench for sr_pulse_gen at DEBOUNCE=4, PULSE=2, GAP=1.
module tb_sr_pulse_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_set = 1'b0;
  logic btn_reset = 1'b0;
  logic s, r, conflict, busy;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sr_pulse_gen #(
    .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(2), .GAP_CYCLES(1)
  ) dut (
    .clk(clk), .rst(rst), .btn_set(btn_set), .btn_reset(btn_reset),
    .s(s), .r(r), .conflict(conflict), .busy(busy)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1ns later; invariants are checked every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    check("s_and_r", s & r, 1'b0);
    check("conflict_with_pulse", conflict & (s | r), 1'b0);
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    // 1: reset with both buttons held, then a conflict once debounce completes
    rst = 1'b1; btn_set = 1'b1; btn_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_s", s, 1'b0);
      check("rst_r", r, 1'b0);
      check("rst_conflict", conflict, 1'b0);
      check("rst_busy", busy, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("t1_conflict", conflict, i == 6);
      check("t1_s", s, 1'b0);
      check("t1_r", r, 1'b0);
      check("t1_busy", busy, 1'b0);
    end
    btn_set = 1'b0; btn_reset = 1'b0;
    settle(12);

    // 2: single set press
    btn_set = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t2_s", s, (i == 6) || (i == 7));
      check("t2_busy", busy, (i >= 6) && (i <= 8));
      check("t2_r", r, 1'b0);
    end
    btn_set = 1'b0;
    settle(12);

    // 3a: 3-cycle glitch on reset is filtered
    btn_reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == 2) btn_reset = 1'b0;
      check("t3a_r", r, 1'b0);
      check("t3a_busy", busy, 1'b0);
    end
    // 3b: 4-cycle press is accepted
    btn_reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 3) btn_reset = 1'b0;
      check("t3b_r", r, (i == 6) || (i == 7));
      check("t3b_busy", busy, (i >= 6) && (i <= 8));
      check("t3b_s", s, 1'b0);
    end
    settle(6);

    // 4: simultaneous press is dropped and leaves nothing pending
    btn_set = 1'b1; btn_reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_conflict", conflict, i == 6);
      check("t4_s", s, 1'b0);
      check("t4_r", r, 1'b0);
      check("t4_busy", busy, 1'b0);
    end
    btn_set = 1'b0; btn_reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("t4_after_s", s, 1'b0);
      check("t4_after_r", r, 1'b0);
      check("t4_after_busy", busy, 1'b0);
    end

    // 5: set then reset two cycles later -> S pulse, gap, R pulse
    btn_set = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 1) btn_reset = 1'b1;
      check("t5_s", s, (i == 6) || (i == 7));
      check("t5_r", r, (i == 10) || (i == 11));
      check("t5_busy", busy, ((i >= 6) && (i <= 8)) || ((i >= 10) && (i <= 12)));
    end
    btn_set = 1'b0; btn_reset = 1'b0;
    settle(12);

    // 6: reset mid S pulse with a reset request pending
    btn_set = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) btn_reset = 1'b1;
      check("t6_s_pre", s, i >= 6);
      check("t6_r_pre", r, 1'b0);
    end
    rst = 1'b1;
    tick();
    check("t6_s_rst", s, 1'b0);
    check("t6_busy_rst", busy, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("t6_s_post", s, 1'b0);
      check("t6_r_post", r, 1'b0);
      check("t6_conflict_post", conflict, i == 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
